// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and response bundle for the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             cmd_clr_acc;

    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [2:0]       alu_ALUOp;
    logic [WIDTH-1:0] alu_C;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_clr_acc,
        input  alu_C, rsp_ready,
        output cmd_ready, alu_A, alu_B, alu_ALUOp,
        output rsp_valid, rsp_result, acc, op_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_clr_acc,
        output alu_C, rsp_ready,
        input  cmd_ready, alu_A, alu_B, alu_ALUOp,
        input  rsp_valid, rsp_result, acc, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives a combinational ALU from registered operands and returns results with an accumulator
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_op_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic             handoff;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] a_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        handoff   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clearing wins over reuse: a cleared accumulator feeds zero into A on the same accept.
    always_comb begin
        a_sel = bus.cmd_a;
        if (bus.cmd_use_acc) begin
            a_sel = bus.cmd_clr_acc ? '0 : acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                a_q  <= a_sel;
                b_q  <= bus.cmd_b;
                op_q <= bus.cmd_op;
                if (bus.cmd_clr_acc) begin
                    acc_q <= '0;
                end
            end
            if (capture) begin
                result_q <= bus.alu_C;
                acc_q    <= bus.alu_C;
            end
            if (handoff) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.alu_A      = a_q;
    assign bus.alu_B      = b_q;
    assign bus.alu_ALUOp  = op_q;
    assign bus.rsp_result = result_q;
    assign bus.acc        = acc_q;
    assign bus.op_count   = count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_use_acc;
    logic        cmd_clr_acc;
    logic        rsp_ready;

    int n_total;
    int n_pass;

    alu_op_sequencer_if #(.WIDTH(32), .CNT_W(16)) bus ();
    alu_op_sequencer_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

    alu_op_sequencer #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu_op_sequencer #(.WIDTH(32), .CNT_W(2)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return 32'($signed(a) >>> b[4:0]);
            3'b110:  return a << b[4:0];
            default: return {31'd0, ($signed(a) < $signed(b))};
        endcase
    endfunction

    assign bus.cmd_valid   = cmd_valid;
    assign bus.cmd_op      = cmd_op;
    assign bus.cmd_a       = cmd_a;
    assign bus.cmd_b       = cmd_b;
    assign bus.cmd_use_acc = cmd_use_acc;
    assign bus.cmd_clr_acc = cmd_clr_acc;
    assign bus.rsp_ready   = rsp_ready;
    assign bus.alu_C       = alu_f(bus.alu_ALUOp, bus.alu_A, bus.alu_B);

    assign bus2.cmd_valid   = cmd_valid;
    assign bus2.cmd_op      = cmd_op;
    assign bus2.cmd_a       = cmd_a;
    assign bus2.cmd_b       = cmd_b;
    assign bus2.cmd_use_acc = cmd_use_acc;
    assign bus2.cmd_clr_acc = cmd_clr_acc;
    assign bus2.rsp_ready   = rsp_ready;
    assign bus2.alu_C       = alu_f(bus2.alu_ALUOp, bus2.alu_A, bus2.alu_B);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ua, input logic ca, input logic [31:0] exp_a, input logic [31:0] exp_c,
                         input logic [15:0] exp_cnt);
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        cmd_clr_acc = ca;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, ".drive_cmd_ready"}, bus.cmd_ready, 0);
        check({tag, ".drive_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, ".alu_A"}, bus.alu_A, exp_a);
        check({tag, ".alu_B"}, bus.alu_B, b);
        check({tag, ".alu_ALUOp"}, bus.alu_ALUOp, op);
        tick();
        check({tag, ".rsp_valid"}, bus.rsp_valid, 1);
        check({tag, ".rsp_result"}, bus.rsp_result, exp_c);
        check({tag, ".acc"}, bus.acc, exp_c);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".op_count"}, bus.op_count, exp_cnt);
        check({tag, ".idle_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, ".idle_rsp_valid"}, bus.rsp_valid, 0);
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        n_total     = 0;
        n_pass      = 0;
        cmd_op      = 3'd0;
        cmd_a       = 32'd0;
        cmd_b       = 32'd0;
        cmd_use_acc = 1'b0;
        cmd_clr_acc = 1'b0;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        reset       = 1'b1;

        // Test 1: reset values, during and after reset, then a simple add
        tick();
        check("rst.cmd_ready", bus.cmd_ready, 1);
        check("rst.rsp_valid", bus.rsp_valid, 0);
        check("rst.alu_A", bus.alu_A, 0);
        check("rst.alu_B", bus.alu_B, 0);
        check("rst.alu_ALUOp", bus.alu_ALUOp, 0);
        check("rst.rsp_result", bus.rsp_result, 0);
        check("rst.acc", bus.acc, 0);
        check("rst.op_count", bus.op_count, 0);
        tick();
        reset = 1'b0;
        check("post_rst.cmd_ready", bus.cmd_ready, 1);
        check("post_rst.rsp_valid", bus.rsp_valid, 0);
        check("post_rst.acc", bus.acc, 0);
        tick();
        check("idle_hold.cmd_ready", bus.cmd_ready, 1);
        check("idle_hold.op_count", bus.op_count, 0);
        do_op("t1_add", 3'b000, 32'd5, 32'd7, 1'b0, 1'b0, 32'd5, 32'd12, 16'd1);

        // Test 2: accumulate chain
        do_reset();
        do_op("t2_a", 3'b000, 32'd10, 32'd0,  1'b0, 1'b0, 32'd10, 32'd10, 16'd1);
        do_op("t2_b", 3'b000, 32'd999, 32'd3, 1'b1, 1'b0, 32'd10, 32'd13, 16'd2);
        do_op("t2_c", 3'b001, 32'd999, 32'd20, 1'b1, 1'b0, 32'd13, 32'hFFFF_FFF9, 16'd3);
        check("t2.acc_end", bus.acc, 32'hFFFF_FFF9);

        // Test 3: clear then sra, and a standalone sra
        do_op("t3_load", 3'b000, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 16'd4);
        do_op("t3_clr", 3'b101, 32'hDEAD_BEEF, 32'd4, 1'b1, 1'b1, 32'd0, 32'd0, 16'd5);
        do_op("t3_sra", 3'b101, 32'hF000_0000, 32'd10, 1'b0, 1'b0, 32'hF000_0000, 32'hFFFC_0000, 16'd6);

        // Test 4: backpressure in RESP
        cmd_op      = 3'b000;
        cmd_a       = 32'd100;
        cmd_b       = 32'd23;
        cmd_use_acc = 1'b0;
        cmd_clr_acc = 1'b0;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_a     = $urandom;
            tick();
            check("t4.rsp_valid", bus.rsp_valid, 1);
            check("t4.rsp_result", bus.rsp_result, 32'd123);
            check("t4.cmd_ready", bus.cmd_ready, 0);
            check("t4.op_count", bus.op_count, 16'd6);
            check("t4.alu_A", bus.alu_A, 32'd100);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4.op_count_rel", bus.op_count, 16'd7);
        check("t4.cmd_ready_rel", bus.cmd_ready, 1);
        tick();
        check("t4.no_accept", bus.cmd_ready, 1);
        check("t4.alu_A_hold", bus.alu_A, 32'd100);

        // Test 5: reset during DRIVE discards the operation
        do_reset();
        cmd_op    = 3'b000;
        cmd_a     = 32'd40;
        cmd_b     = 32'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t5.in_drive", bus.cmd_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5.cmd_ready", bus.cmd_ready, 1);
        check("t5.rsp_valid", bus.rsp_valid, 0);
        check("t5.acc", bus.acc, 0);
        check("t5.op_count", bus.op_count, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5.no_rsp", bus.rsp_valid, 0);
            check("t5.no_result", bus.rsp_result, 0);
        end
        rsp_ready = 1'b0;
        check("t5.op_count_end", bus.op_count, 0);

        // Test 6: 2-bit counter wraps
        do_reset();
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            do_op("t6_op", 3'b000, 32'(i), 32'd1, 1'b0, 1'b0, 32'(i), 32'(i + 1), 16'(i + 1));
            check("t6.wrap_count", bus2.op_count, wrap_exp[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Master-side driver for the team's combinational 32-bit ALU (operands A, B; 3-bit ALUOp; result C). It accepts operation commands over a valid/ready handshake and drives the ALU's A/B/ALUOp inputs from stable registers. It captures C into a result register and an internal accumulator, then presents the result over a second valid/ready handshake. It sits between a command source (testbench or control logic) and the ALU, enabling chained accumulate operations.

Parameters:
WIDTH, 32, datapath width of operands, result and accumulator
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  ALUOp to issue
cmd_a  input  WIDTH  operand A, used when cmd_use_acc=0
cmd_b  input  WIDTH  operand B
cmd_use_acc  input  1  1: A is taken from the accumulator instead of cmd_a
cmd_clr_acc  input  1  1: accumulator is zeroed at accept, before A is selected
alu_A  output  WIDTH  to ALU input A
alu_B  output  WIDTH  to ALU input B
alu_ALUOp  output  3  to ALU input ALUOp
alu_C  input  WIDTH  from ALU output C (combinational)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_result  output  WIDTH  captured ALU result
acc  output  WIDTH  current accumulator value
op_count  output  CNT_W  number of completed (handed-off) operations

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) puts the block in IDLE on that edge.
  - Zeroed outputs: alu_A, alu_B, alu_ALUOp, rsp_result, acc, op_count, rsp_valid.
  - cmd_ready=1 in the first cycle after reset.
  - Reset has priority over every other event in any state; an in-flight operation is discarded and not counted.
- FSM states are IDLE, DRIVE and RESP. All outputs are registered or decoded from the state only; there are no combinational paths from cmd_* or rsp_ready to outputs.
- IDLE:
  - cmd_ready=1, rsp_valid=0.
  - On cmd_valid=1 at an edge, the command is accepted:
    - alu_ALUOp <= cmd_op; alu_B <= cmd_b.
    - alu_A <= cmd_use_acc ? (cmd_clr_acc ? 0 : acc) : cmd_a.
    - If cmd_clr_acc=1, acc <= 0.
    - Next state is DRIVE.
  - With cmd_valid=0, the block stays in IDLE and all registers hold.
- DRIVE (exactly one cycle):
  - cmd_ready=0, rsp_valid=0; alu_* are stable from the accepting edge.
  - At the edge closing DRIVE: rsp_result <= alu_C and acc <= alu_C; next state is RESP.
- RESP:
  - rsp_valid=1, rsp_result held, cmd_ready=0.
  - On rsp_ready=1 at an edge: op_count <= op_count+1, which wraps modulo 2^CNT_W; next state is IDLE.
  - Otherwise the block stays in RESP, holding everything, for unbounded backpressure.
- Latency and throughput:
  - A command accepted at edge N gives rsp_valid=1 in the cycle after edge N+1.
  - With rsp_ready held at 1, one operation completes every 3 cycles.
- cmd_* inputs are don't-care outside IDLE.
- alu_A, alu_B and alu_ALUOp hold their last values after the operation until the next accept.
- Arithmetic is performed solely by the external ALU. The sequencer passes values unmodified, with no width extension or truncation.

Test Plan:
1. Reset, then add: assert reset 2 cycles, then issue op=000 (add), a=5, b=7, use_acc=0.
   - During reset and the cycle after: all outputs 0 except cmd_ready=1.
   - rsp_result=12 with rsp_valid two cycles after accept; acc=12; op_count=1 after rsp_ready.
2. Accumulate chain: op=000, a=10, b=0; then op=000, use_acc=1, b=3; then op=001 (sub), use_acc=1, b=20.
   - Results in order: 10, 13, 0xFFFFFFF9; acc ends at 0xFFFFFFF9; op_count=3.
3. Clear plus shift: acc=0x12345678, then op=101 (sra), use_acc=1, clr_acc=1, b=4.
   - alu_A=0, rsp_result=0, acc=0.
   - Separately, op=101, a=0xF0000000, b=10 gives 0xFFFC0000.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling cmd_valid and cmd_a.
   - rsp_valid stays 1, rsp_result is unchanged and cmd_ready=0.
   - No command is accepted; op_count increments once when rsp_ready rises.
5. Reset mid-operation: accept a command, assert reset during DRIVE.
   - Next cycle: IDLE, rsp_valid=0, acc=0, op_count unchanged at 0, and the result never appears.
6. Counter wrap: with CNT_W=2, complete 5 operations.
   - op_count sequence is 1,2,3,0,1.
